// File: rtl/tpu_matmul_engine_if.sv
// Host-side bus of the matrix-multiply engine: element write port, P read port,
// start/mode control and status flags.
interface tpu_matmul_engine_if #(
  parameter int DW     = 8,
  parameter int PW     = 16,
  parameter int ADDR_W = 4
);
  logic [1:0]        mem_acc;
  logic [ADDR_W-1:0] wr_addr;
  logic [DW-1:0]     data_in;
  logic [ADDR_W-1:0] rd_addr;
  logic              start;
  logic              acc_mode;
  logic [PW-1:0]     data_out;
  logic              out_valid;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output mem_acc, wr_addr, data_in, rd_addr, start, acc_mode,
    input  data_out, out_valid, busy, done, err
  );

  modport slave (
    input  mem_acc, wr_addr, data_in, rd_addr, start, acc_mode,
    output data_out, out_valid, busy, done, err
  );
endinterface

// File: rtl/tpu_matmul_engine.sv
// NxN unsigned matrix-multiply engine: P = A x W or P += A x W, one k-step per cycle,
// with all N*N saturating accumulators updated in parallel.
module tpu_matmul_engine #(
  parameter int N      = 4,
  parameter int DW     = 8,
  parameter int ACC_W  = 24,
  parameter int PW     = 16,
  parameter int ADDR_W = 4
) (
  input logic                  clk,
  input logic                  rst,
  tpu_matmul_engine_if.slave   bus
);

  localparam int NN = N * N;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [ADDR_W:0]  NN_LIM  = (ADDR_W + 1)'(NN);
  localparam logic [KW-1:0]    K_LAST  = KW'(N - 1);
  localparam logic [ACC_W-1:0] OUT_MAX = (ACC_W'(1) << PW) - ACC_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_e;
  typedef enum logic [1:0] {
    ACC_NONE = 2'b00,
    ACC_WR_A = 2'b01,
    ACC_WR_W = 2'b10,
    ACC_RD_P = 2'b11
  } mem_acc_e;

  state_e            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [DW-1:0]     a_q   [NN];
  logic [DW-1:0]     a_d   [NN];
  logic [DW-1:0]     w_q   [NN];
  logic [DW-1:0]     w_d   [NN];
  logic [ACC_W-1:0]  acc_q [NN];
  logic [ACC_W-1:0]  acc_d [NN];
  logic [PW-1:0]     data_out_q, data_out_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic wr_ok, rd_ok;
  assign wr_ok = {1'b0, bus.wr_addr} < NN_LIM;
  assign rd_ok = {1'b0, bus.rd_addr} < NN_LIM;

  // Saturating multiply-accumulate: once at the ceiling the value stays there.
  function automatic logic [ACC_W-1:0] mac_sat(input logic [ACC_W-1:0] acc,
                                               input logic [DW-1:0]    a,
                                               input logic [DW-1:0]    w);
    logic [2*DW-1:0] prod;
    logic [ACC_W:0]  sum;
    prod = a * w;
    sum  = {1'b0, acc} + (ACC_W + 1)'(prod);
    return sum[ACC_W] ? '1 : sum[ACC_W-1:0];
  endfunction

  function automatic logic [PW-1:0] clip_out(input logic [ACC_W-1:0] acc);
    return (acc > OUT_MAX) ? PW'(OUT_MAX) : PW'(acc);
  endfunction

  always_comb begin
    // NOTE: every _d starts from a default so no path leaves it unassigned (no latches).
    state_d     = state_q;
    k_d         = k_q;
    a_d         = a_q;
    w_d         = w_q;
    acc_d       = acc_q;
    data_out_d  = data_out_q;
    out_valid_d = 1'b0;
    err_d       = 1'b0;

    if (state_q == S_MAC) begin
      // Any host request while computing is dropped; only the error flag reacts.
      err_d = (mem_acc_e'(bus.mem_acc) != ACC_NONE) || bus.start;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          acc_d[i*N + j] = mac_sat(acc_q[i*N + j],
                                   a_q[i*N + int'(k_q)],
                                   w_q[int'(k_q)*N + j]);
        end
      end
      if (k_q == K_LAST) begin
        state_d = S_DONE;
        k_d     = '0;
      end else begin
        k_d = k_q + KW'(1);
      end
    end else begin
      unique case (mem_acc_e'(bus.mem_acc))
        ACC_WR_A: if (wr_ok) a_d[bus.wr_addr] = bus.data_in; else err_d = 1'b1;
        ACC_WR_W: if (wr_ok) w_d[bus.wr_addr] = bus.data_in; else err_d = 1'b1;
        ACC_RD_P: begin
          if (rd_ok) begin
            data_out_d  = clip_out(acc_q[bus.rd_addr]);
            out_valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: ;
      endcase

      // A same-edge write has already landed in a_d/w_d, so the first MAC step sees it.
      if (bus.start) begin
        state_d = S_MAC;
        k_d     = '0;
        if (!bus.acc_mode) begin
          for (int e = 0; e < NN; e++) acc_d[e] = '0;
        end
      end else if (state_q == S_DONE) begin
        state_d = S_IDLE;
      end
    end

    busy_d = (state_d == S_MAC);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      // NOTE: the stores are reset too, since a reset (even mid-run) must leave P reading zero.
      for (int e = 0; e < NN; e++) begin
        a_q[e]   <= '0;
        w_q[e]   <= '0;
        acc_q[e] <= '0;
      end
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      k_q         <= k_d;
      a_q         <= a_d;
      w_q         <= w_d;
      acc_q       <= acc_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_tpu_matmul_engine.sv
// Self-checking bench for tpu_matmul_engine: directed scenarios plus random matrices
// compared against a whole-matrix arithmetic reference model.
module tb_tpu_matmul_engine;

  localparam int N      = 4;
  localparam int NN     = N * N;
  localparam int DW     = 8;
  localparam int ACC_W  = 24;
  localparam int PW     = 16;
  localparam int ADDR_W = 4;
  localparam longint ACC_MAX = (64'd1 << ACC_W) - 1;
  localparam longint OUT_MAX = (64'd1 << PW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tpu_matmul_engine_if #(.DW(DW), .PW(PW), .ADDR_W(ADDR_W)) bus ();

  tpu_matmul_engine #(
    .N(N), .DW(DW), .ACC_W(ACC_W), .PW(PW), .ADDR_W(ADDR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  longint a_m [NN];
  longint w_m [NN];
  longint p_m [NN];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: P becomes (mode ? P : 0) + A x W, clamped at the accumulator ceiling.
  function automatic void model_run(input bit mode);
    longint s;
    longint nxt [NN];
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        s = mode ? p_m[i*N + j] : 0;
        for (int k = 0; k < N; k++) s += a_m[i*N + k] * w_m[k*N + j];
        nxt[i*N + j] = (s > ACC_MAX) ? ACC_MAX : s;
      end
    end
    p_m = nxt;
  endfunction

  function automatic logic [31:0] out_of(input int idx);
    return 32'((p_m[idx] > OUT_MAX) ? OUT_MAX : p_m[idx]);
  endfunction

  task automatic write_el(input logic [1:0] sel, input int addr, input int val);
    bus.mem_acc = sel;
    bus.wr_addr = ADDR_W'(addr);
    bus.data_in = DW'(val);
    tick();
    bus.mem_acc = 2'b00;
    if (sel == 2'b01) a_m[addr] = val;
    else              w_m[addr] = val;
  endtask

  task automatic read_one(input int addr, input logic [31:0] exp, input string tag);
    bus.mem_acc = 2'b11;
    bus.rd_addr = ADDR_W'(addr);
    tick();
    bus.mem_acc = 2'b00;
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check(tag, 32'(bus.data_out), exp);
  endtask

  // Back-to-back reads of every P element, then one idle cycle to see data_out hold.
  task automatic read_all(input string tag);
    for (int i = 0; i < NN; i++) begin
      bus.mem_acc = 2'b11;
      bus.rd_addr = ADDR_W'(i);
      tick();
      check($sformatf("%s_valid[%0d]", tag, i), 32'(bus.out_valid), 32'd1);
      check($sformatf("%s_p[%0d]", tag, i), 32'(bus.data_out), out_of(i));
    end
    bus.mem_acc = 2'b00;
    tick();
    check({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_hold"}, 32'(bus.data_out), out_of(NN - 1));
  endtask

  // Start a run (optionally with a same-edge W write) and check busy/done timing.
  task automatic run(input bit mode, input bit with_wr, input int wr_val, input string tag);
    bus.start    = 1'b1;
    bus.acc_mode = mode;
    if (with_wr) begin
      bus.mem_acc = 2'b10;
      bus.wr_addr = ADDR_W'(NN - 1);
      bus.data_in = DW'(wr_val);
      w_m[NN - 1] = wr_val;
    end
    tick();
    bus.start   = 1'b0;
    bus.mem_acc = 2'b00;
    model_run(mode);
    check({tag, "_busy0"}, 32'(bus.busy), 32'd1);
    for (int c = 1; c < N; c++) begin
      tick();
      check($sformatf("%s_busy%0d", tag, c), {31'd0, bus.busy, 30'd0} >> 30, 32'd1 << 0);
    end
    tick();
    check({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    tick();
    check({tag, "_done_drop"}, 32'(bus.done), 32'd0);
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      tick();
      if (bus.done) n++;
    end
  endtask

  initial begin
    int rowa [4][4];
    int ndone;
    int lim;
    rowa = '{'{4, 0, 2, 1}, '{4, 3, 2, 0}, '{4, 3, 0, 1}, '{4, 3, 2, 1}};

    rst = 1'b1;
    bus.mem_acc = 2'b00; bus.wr_addr = '0; bus.data_in = '0; bus.rd_addr = '0;
    bus.start = 1'b0; bus.acc_mode = 1'b0;
    for (int e = 0; e < NN; e++) begin a_m[e] = 0; w_m[e] = 0; p_m[e] = 0; end
    repeat (3) tick();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_dout", 32'(bus.data_out), 32'd0);
    rst = 1'b0;
    tick();

    // Reset contents read back as zero, one result per cycle.
    read_all("t1");

    // Directed example matrices.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        write_el(2'b01, i*N + j, rowa[i][j]);
        write_el(2'b10, i*N + j, j + 1);
      end
    run(1'b0, 1'b0, 0, "t2_run");
    read_one(0, 32'd7, "t2_p0");
    read_one(5, 32'd18, "t2_p5");
    read_one(10, 32'd24, "t2_p10");
    read_one(15, 32'd40, "t2_p15");
    read_all("t2");

    // Accumulate mode, then overwrite mode.
    run(1'b1, 1'b0, 0, "t3_acc");
    read_one(0, 32'd14, "t3_p0");
    read_one(15, 32'd80, "t3_p15");
    run(1'b0, 1'b0, 0, "t3_clr");
    read_one(0, 32'd7, "t3_p0b");

    // Output saturation.
    for (int e = 0; e < NN; e++) begin
      write_el(2'b01, e, 255);
      write_el(2'b10, e, 255);
    end
    run(1'b0, 1'b0, 0, "t4_run");
    read_all("t4");

    // Illegal requests while busy: dropped, err pulses, exactly one done.
    for (int e = 0; e < NN; e++) write_el(2'b01, e, (e % 7) + 1);
    bus.start = 1'b1; bus.acc_mode = 1'b0;
    tick();
    bus.start = 1'b0;
    model_run(1'b0);
    bus.mem_acc = 2'b01; bus.wr_addr = '0; bus.data_in = 8'd9; bus.start = 1'b1;
    tick();
    check("t5_err_wr_start", 32'(bus.err), 32'd1);
    bus.mem_acc = 2'b11; bus.rd_addr = '0; bus.start = 1'b0;
    tick();
    check("t5_err_rd", 32'(bus.err), 32'd1);
    check("t5_rd_dropped", 32'(bus.out_valid), 32'd0);
    bus.mem_acc = 2'b00;
    tick();
    check("t5_err_drop", 32'(bus.err), 32'd0);
    count_done(2 * N, ndone);
    check("t5_one_done", 32'(ndone), 32'd1);
    read_all("t5");

    // Start during the done cycle restarts without repeating done.
    bus.start = 1'b1; bus.acc_mode = 1'b0;
    tick();
    bus.start = 1'b0;
    model_run(1'b0);
    repeat (N) tick();
    check("t6_done_before", 32'(bus.done), 32'd1);
    bus.start = 1'b1; bus.acc_mode = 1'b1;
    tick();
    bus.start = 1'b0;
    model_run(1'b1);
    check("t6_restart_busy", 32'(bus.busy), 32'd1);
    check("t6_restart_nodone", 32'(bus.done), 32'd0);
    count_done(2 * N, ndone);
    check("t6_one_done", 32'(ndone), 32'd1);
    read_all("t6");

    // Random matrices; the final W element is written on the start edge.
    for (int r = 0; r < 6; r++) begin
      lim = (r % 2 == 0) ? 15 : 255;
      for (int e = 0; e < NN; e++) begin
        write_el(2'b01, e, int'($urandom_range(0, lim)));
        if (e < NN - 1) write_el(2'b10, e, int'($urandom_range(0, lim)));
      end
      run(bit'(r % 3 == 2), 1'b1, int'($urandom_range(0, lim)), $sformatf("rnd%0d", r));
      read_all($sformatf("rnd%0d", r));
    end

    // Reset in the second MAC cycle aborts the run and clears everything.
    bus.start = 1'b1; bus.acc_mode = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int e = 0; e < NN; e++) begin a_m[e] = 0; w_m[e] = 0; p_m[e] = 0; end
    check("t7_busy", 32'(bus.busy), 32'd0);
    check("t7_done", 32'(bus.done), 32'd0);
    count_done(2 * N, ndone);
    check("t7_no_done", 32'(ndone), 32'd0);
    read_all("t7");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
